sid_filter_sequencer: RTL
=========================

// Module: sid_filter_sequencer
// PURPOSE
//  Sample-rate scheduler and register front-end for the SID filter/mixer datapath (sid_filters).
//  Generates the per-sample launch strobe and snapshots voice/ext inputs so they are stable for the
//  filter's 13-cycle pass. Double-buffers the four filter registers so CPU writes only take effect
//  between samples. Captures each finished sample into a valid/ready holding register for the DAC.
// PARAMETERS
//  SAMPLE_DIV  750  clk cycles per audio sample (24 MHz -> 32 kHz); legal range 16..65535
//  TIMEOUT     32   max cycles to wait for filt_valid after launch; must be > 13
// PORTS
//  clk            in   1   system clock, >= 12 MHz
//  rst            in   1   synchronous, active-high reset
//  reg_we         in   1   CPU write strobe, one cycle
//  reg_addr       in   2   0=Fc_lo 1=Fc_hi 2=Res_Filt 3=Mode_Vol (SID $15-$18)
//  reg_din        in   8   write data
//  voice1..3      in   13  signed voice samples, free-running
//  ext_in         in   13  signed external input, free-running
//  Fc_lo,Fc_hi,Res_Filt,Mode_Vol  out 8 each  committed registers to filter
//  f_voice1..3    out  13  latched voices to filter
//  f_ext_in       out  13  latched ext input to filter
//  f_input_valid  out  1   one-cycle launch strobe to filter
//  f_sound        in   19  signed filter result
//  f_valid        in   1   filter result strobe
//  out_sample     out  19  signed sample held for DAC
//  out_valid      out  1   out_sample valid
//  out_ready      in   1   DAC accepts when out_valid & out_ready
//  overrun        out  1   sticky: tick arrived while filter busy
//  timeout_err    out  1   sticky: filter failed to answer within TIMEOUT
//  drop_cnt       out  8   saturating count of samples overwritten before acceptance
// BEHAVIOUR
//  Reset: every output and shadow/committed register = 0; divider = 0; state IDLE.
//  Divider: counts 0..SAMPLE_DIV-1; tick = (cnt == SAMPLE_DIV-1), one cycle per sample period.
//  Shadow regs: reg_we writes shadow[reg_addr] on the same edge. Committed regs change only at launch.
//  FSM IDLE -> LAUNCH -> WAIT -> IDLE:
//   IDLE:   on tick: committed <= shadow, f_voice*/f_ext_in <= inputs; go LAUNCH.
//   LAUNCH: f_input_valid = 1 (exactly one cycle); clear wait counter; go WAIT.
//   WAIT:   on f_valid: out_sample <= f_sound, out_valid <= 1; go IDLE.
//           wait counter reaches TIMEOUT with no f_valid: timeout_err <= 1, no sample; go IDLE.
//  Latency: tick -> f_input_valid = 1 cycle; f_valid -> out_valid = 1 cycle.
//  Tick in LAUNCH or WAIT: tick dropped, overrun <= 1; divider keeps running (no phase slip).
//  reg_we coinciding with the commit edge: commit takes the pre-write shadow; the write lands in
//   shadow and commits at the next tick.
//  f_valid outside WAIT is ignored.
//  Output handshake: out_valid clears on out_valid & out_ready.
//   New capture while out_valid=1 and not accepted this cycle: overwrite out_sample,
//   keep out_valid=1, drop_cnt += 1 (saturates at 255).
//   Capture and acceptance on the same edge: no drop; out_valid stays 1 with the new sample.
//  f_voice*, f_ext_in and the committed regs are held constant from launch until the next launch.
//  rst mid-operation: return to IDLE; any in-flight result is discarded.
//   The filter shares rst, so both blocks restart together.
//  overrun/timeout_err clear only on rst.
// STRUCTURE
//  Shared package sid_pkg: register address constants (SID_FC_LO..SID_MODE_VOL), sample width
//   consts (VOICE_W=13, SOUND_W=19), FSM state encoding.
//  One natural sub-module: sid_sample_tick (divider, parameter SAMPLE_DIV, outputs tick).
//  The remainder (FSM, shadow/commit, output holding) is flat in this module.
//  The bench instantiates this block with sid_filters and a stub filter.
// TESTING
//  1. SAMPLE_DIV=16, stub answers 13 cycles after launch with f_sound=19'h12345
//     -> f_input_valid every 16 cycles, out_valid 1 cycle after f_valid, out_sample=19'h12345.
//  2. Write Fc_hi=8'hA5 at 5 cycles, then again exactly on a commit edge with 8'h3C
//     -> first launch shows Fc_hi=A5; the following launch shows 3C.
//  3. Voices change every cycle during WAIT -> f_voice1..3 stay at the values latched at launch.
//  4. SAMPLE_DIV=16, stub delays 20 cycles -> overrun=1 after first overlapping tick;
//     divider period stays 16.
//  5. Stub never asserts f_valid -> timeout_err=1 at TIMEOUT cycles after launch;
//     FSM back in IDLE; next tick launches normally.
//  6. out_ready=0 for 300 samples -> drop_cnt saturates at 255.
//     Then out_ready=1 on a capture edge -> no drop counted, out_valid stays 1.
//     Assert rst in WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared constants for the SID filter front-end: register map, sample widths, sequencer states.
package sid_pkg;
  localparam int VOICE_W = 13;
  localparam int SOUND_W = 19;

  localparam logic [1:0] SID_FC_LO    = 2'd0;
  localparam logic [1:0] SID_FC_HI    = 2'd1;
  localparam logic [1:0] SID_RES_FILT = 2'd2;
  localparam logic [1:0] SID_MODE_VOL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } seq_state_t;
endpackage

// File: rtl/sid_sample_tick.sv
// Free-running sample-rate divider; tick is high for one clk per SAMPLE_DIV cycles.
module sid_sample_tick #(
  parameter int SAMPLE_DIV = 750
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [15:0] cnt;

  assign tick = (cnt == 16'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 16'd1;
  end
endmodule

// File: rtl/sid_filter_sequencer.sv
// Sample scheduler and register front-end for sid_filters: launches one filter pass per
// sample, double-buffers the filter registers and holds each result for the DAC.
module sid_filter_sequencer
  import sid_pkg::*;
#(
  parameter int SAMPLE_DIV = 750,
  parameter int TIMEOUT    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reg_we,
  input  logic [1:0]                reg_addr,
  input  logic [7:0]                reg_din,
  input  logic signed [VOICE_W-1:0] voice1,
  input  logic signed [VOICE_W-1:0] voice2,
  input  logic signed [VOICE_W-1:0] voice3,
  input  logic signed [VOICE_W-1:0] ext_in,
  output logic [7:0]                Fc_lo,
  output logic [7:0]                Fc_hi,
  output logic [7:0]                Res_Filt,
  output logic [7:0]                Mode_Vol,
  output logic signed [VOICE_W-1:0] f_voice1,
  output logic signed [VOICE_W-1:0] f_voice2,
  output logic signed [VOICE_W-1:0] f_voice3,
  output logic signed [VOICE_W-1:0] f_ext_in,
  output logic                      f_input_valid,
  input  logic signed [SOUND_W-1:0] f_sound,
  input  logic                      f_valid,
  output logic signed [SOUND_W-1:0] out_sample,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overrun,
  output logic                      timeout_err,
  output logic [7:0]                drop_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_t       state, state_nxt;
  logic             tick;
  logic [3:0][7:0]  shadow, committed;
  logic [TW-1:0]    wcnt;
  logic             launch, capture, expire, accept;

  sid_sample_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign launch        = (state == ST_IDLE) && tick;
  assign capture       = (state == ST_WAIT) && f_valid;
  // wcnt holds cycles since launch, so the flag shows exactly TIMEOUT cycles after it
  assign expire        = (state == ST_WAIT) && !f_valid && (wcnt == TW'(TIMEOUT - 1));
  assign accept        = out_valid && out_ready;
  assign f_input_valid = (state == ST_LAUNCH);

  assign Fc_lo    = committed[SID_FC_LO];
  assign Fc_hi    = committed[SID_FC_HI];
  assign Res_Filt = committed[SID_RES_FILT];
  assign Mode_Vol = committed[SID_MODE_VOL];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (launch) state_nxt = ST_LAUNCH;
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT:   if (capture || expire) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      committed   <= '0;
      f_voice1    <= '0;
      f_voice2    <= '0;
      f_voice3    <= '0;
      f_ext_in    <= '0;
      wcnt        <= '0;
      out_sample  <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (reg_we) shadow[reg_addr] <= reg_din;
      // commit samples the pre-write shadow when a write lands on the same edge
      if (launch) begin
        committed <= shadow;
        f_voice1  <= voice1;
        f_voice2  <= voice2;
        f_voice3  <= voice3;
        f_ext_in  <= ext_in;
      end
      if (tick && state != ST_IDLE) overrun <= 1'b1;
      if (state == ST_LAUNCH)     wcnt <= TW'(1);
      else if (state == ST_WAIT)  wcnt <= wcnt + TW'(1);
      if (expire) timeout_err <= 1'b1;
      if (capture) begin
        out_sample <= f_sound;
        out_valid  <= 1'b1;
        if (out_valid && !out_ready && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
